alu_sequencer: RTL and testbench
================================

# alu_sequencer

Operation sequencer that drives the datapath's combinational 32-bit ALU through its 3-bit ALU control line.
- Accepts an operation request (ALUOp, funct, operands) over a start/busy/done handshake and decodes it to the control code.
- Presents operands to the ALU and registers the ALU's sum and status outputs.
- Runs 32-bit multiply as a 32-cycle shift-add loop built on the ALU's ADD code.
- Sits between the control unit and the ALU. It replaces the purely combinational ALU-control decode and adds a multi-cycle MULT.

## Interface
- No parameters. Widths are fixed: 32-bit data, 3-bit control, 3-bit status.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request strobe; sampled only in IDLE
- aluop  in  2  00 ADD, 01 SUB, 10 R-type (use funct), 11 illegal
- funct  in  6  R-type function field
- a, b  in  32  operands; latched when start is accepted
- busy  out  1  high in EXEC, MULT and DONE
- done  out  1  one-cycle pulse; result, status and err are valid while high and held afterwards
- result  out  32  registered result
- status  out  3  registered flags: [2] zero, [1] negative, [0] overflow
- err  out  1  registered illegal-operation flag
- alu_a, alu_b  out  32  operands driven to the ALU
- gin  out  3  ALU control line
- alu_sum  in  32  ALU sum output
- alu_status  in  3  ALU status output

## Operation
- Decode is performed on the inputs at start acceptance and the result is latched.
  - aluop 00 → 010; aluop 01 → 110.
  - aluop 10, by funct:
    - 100000 → 010
    - 100010 → 110
    - 100100 → 000
    - 100101 → 001
    - 101010 → 111
    - 000000 → 101 (computes a<<b)
    - 011000 → MULT
  - Anything else is illegal.
- States: IDLE, EXEC, MULT, DONE.
  - IDLE & start & legal single-cycle op → EXEC.
  - IDLE & start & MULT → MULT, with count=0, acc=0, mcand=a, mplier=b.
  - IDLE & start & illegal → DONE, with result=0, status=000, err=1.
  - EXEC → DONE. Capture result=alu_sum, status=alu_status, err=0.
  - MULT, each cycle:
    - drive alu_a=acc, alu_b = mplier[0] ? mcand : 0, gin=010;
    - acc<=alu_sum; mcand<=mcand<<1; mplier<=mplier>>1; count++.
    - After count=31: → DONE, result=low 32 bits of acc, status={~|acc, acc[31], 0}, err=0.
  - DONE → IDLE unconditionally. done=1 only in DONE.
- EXEC drives the latched operands and gin.
- In IDLE and DONE, drive alu_a=0, alu_b=0, gin=010.
- start is ignored outside IDLE.
- a and b may change after acceptance without effect.
- MULT is two's-complement modulo 2^32: low word only, no overflow detection.

## Timing
- Reset (asynchronous, any state) forces:
  - state=IDLE, busy=0, done=0;
  - result=0, status=000, err=0;
  - alu_a=0, alu_b=0, gin=010;
  - internal acc, mcand, mplier and count cleared.
- Reset mid-operation aborts the operation; no done pulse is generated.
- Start accepted at edge k:
  - single-cycle op: done high in the cycle after edge k+1 (latency 2);
  - illegal op: done high after edge k (latency 1);
  - MULT: done high after edge k+32 (latency 33).
- busy rises after edge k and falls with the return to IDLE.
- A new start is accepted in the first IDLE cycle, i.e. the cycle after the done pulse.
- At most one result capture per operation; outputs hold until the next capture or reset.

## Test plan
- ADD: aluop=00, a=5, b=7 → done 2 cycles after start; result=12, status=000, err=0. During EXEC gin=010.
- SUB to zero: aluop=10, funct=100010, a=3, b=3 → result=0, status=100.
- SLT: aluop=10, funct=101010, a=0xFFFFFFFF, b=1 → result=1, gin=111 in EXEC.
- MULT: funct=011000, a=7, b=0xFFFFFFFD → done at start+33, result=0xFFFFFFEB, status=010. A second start pulsed mid-run is ignored.
- Illegal: aluop=10, funct=111111 → done after 1 cycle; err=1, result=0, status=000.
- Reset: assert rst_n=0 at MULT cycle 10 → immediately busy=0 and outputs at reset values; no done pulse. A following ADD 1+1 gives result=2.

Source files
------------

// File: rtl/alu_sequencer.sv
// Operation sequencer in front of a combinational 32-bit ALU: decodes requests to the
// 3-bit ALU control code, registers ALU results, and runs MULT as a 32-step shift-add loop.
module alu_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  aluop,
    input  logic [5:0]  funct,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic [2:0]  status,
    output logic        err,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [2:0]  gin,
    input  logic [31:0] alu_sum,
    input  logic [2:0]  alu_status
);

    localparam logic [2:0] GIN_AND = 3'b000;
    localparam logic [2:0] GIN_OR  = 3'b001;
    localparam logic [2:0] GIN_ADD = 3'b010;
    localparam logic [2:0] GIN_SLL = 3'b101;
    localparam logic [2:0] GIN_SUB = 3'b110;
    localparam logic [2:0] GIN_SLT = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        MULT = 2'd2,
        DONE = 2'd3
    } state_t;

    // Decoded request packed as {legal, mult, gin}; illegal requests fall to the ADD code.
    function automatic logic [4:0] decode_op(input logic [1:0] op, input logic [5:0] fn);
        logic [4:0] d;
        d = {1'b0, 1'b0, GIN_ADD};
        case (op)
            2'b00: d = {1'b1, 1'b0, GIN_ADD};
            2'b01: d = {1'b1, 1'b0, GIN_SUB};
            2'b10: begin
                case (fn)
                    6'b100000: d = {1'b1, 1'b0, GIN_ADD};
                    6'b100010: d = {1'b1, 1'b0, GIN_SUB};
                    6'b100100: d = {1'b1, 1'b0, GIN_AND};
                    6'b100101: d = {1'b1, 1'b0, GIN_OR};
                    6'b101010: d = {1'b1, 1'b0, GIN_SLT};
                    6'b000000: d = {1'b1, 1'b0, GIN_SLL};
                    6'b011000: d = {1'b1, 1'b1, GIN_ADD};
                    default:   d = {1'b0, 1'b0, GIN_ADD};
                endcase
            end
            default: d = {1'b0, 1'b0, GIN_ADD};
        endcase
        return d;
    endfunction

    state_t      state_r;
    state_t      state_s;
    logic [4:0]  dec_s;
    logic [31:0] opa_r;
    logic [31:0] opb_r;
    logic [2:0]  gin_r;
    logic [31:0] acc_r;
    logic [31:0] mcand_r;
    logic [31:0] mplier_r;
    logic [4:0]  count_r;
    logic        busy_r;
    logic        done_r;
    logic [31:0] result_r;
    logic [2:0]  status_r;
    logic        err_r;
    logic [31:0] alu_a_s;
    logic [31:0] alu_b_s;
    logic [2:0]  gin_s;

    // Decode the live request inputs; only consumed on the accepting edge.
    always_comb begin
        dec_s = decode_op(aluop, funct);
    end

    // Next-state selection.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    if (!dec_s[4]) begin
                        state_s = DONE;
                    end else if (dec_s[3]) begin
                        state_s = MULT;
                    end else begin
                        state_s = EXEC;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            EXEC: state_s = DONE;
            MULT: begin
                if (count_r == 5'd31) begin
                    state_s = DONE;
                end else begin
                    state_s = MULT;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // ALU operand and control drive; idle states park the ALU on 0 + 0.
    always_comb begin
        alu_a_s = 32'd0;
        alu_b_s = 32'd0;
        gin_s   = GIN_ADD;
        case (state_r)
            EXEC: begin
                alu_a_s = opa_r;
                alu_b_s = opb_r;
                gin_s   = gin_r;
            end
            MULT: begin
                alu_a_s = acc_r;
                alu_b_s = mplier_r[0] ? mcand_r : 32'd0;
                gin_s   = GIN_ADD;
            end
            default: begin
                alu_a_s = 32'd0;
                alu_b_s = 32'd0;
                gin_s   = GIN_ADD;
            end
        endcase
    end

    // State register with busy/done registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s != IDLE);
            done_r  <= (state_s == DONE);
        end
    end

    // Operand latching, multiply loop registers and the single result capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opa_r    <= 32'd0;
            opb_r    <= 32'd0;
            gin_r    <= GIN_ADD;
            acc_r    <= 32'd0;
            mcand_r  <= 32'd0;
            mplier_r <= 32'd0;
            count_r  <= 5'd0;
            result_r <= 32'd0;
            status_r <= 3'b000;
            err_r    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        opa_r    <= a;
                        opb_r    <= b;
                        gin_r    <= dec_s[2:0];
                        acc_r    <= 32'd0;
                        mcand_r  <= a;
                        mplier_r <= b;
                        count_r  <= 5'd0;
                        if (!dec_s[4]) begin
                            result_r <= 32'd0;
                            status_r <= 3'b000;
                            err_r    <= 1'b1;
                        end
                    end
                end
                EXEC: begin
                    result_r <= alu_sum;
                    status_r <= alu_status;
                    err_r    <= 1'b0;
                end
                MULT: begin
                    acc_r    <= alu_sum;
                    mcand_r  <= {mcand_r[30:0], 1'b0};
                    mplier_r <= {1'b0, mplier_r[31:1]};
                    count_r  <= count_r + 5'd1;
                    if (count_r == 5'd31) begin
                        result_r <= alu_sum;
                        status_r <= {~|alu_sum, alu_sum[31], 1'b0};
                        err_r    <= 1'b0;
                    end
                end
                default: begin
                    count_r <= count_r;
                end
            endcase
        end
    end

    assign busy   = busy_r;
    assign done   = done_r;
    assign result = result_r;
    assign status = status_r;
    assign err    = err_r;
    assign alu_a  = alu_a_s;
    assign alu_b  = alu_b_s;
    assign gin    = gin_s;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: behavioural ALU plus an operation-level reference
// model; directed test-plan cases, randomized operations, back-to-back and reset abort.
module tb_alu_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  aluop;
    logic [5:0]  funct;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [2:0]  status;
    logic        err;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  gin;
    logic [31:0] alu_sum;
    logic [2:0]  alu_status;

    int errors = 0;
    int checks = 0;

    alu_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .aluop(aluop), .funct(funct),
        .a(a), .b(b), .busy(busy), .done(done), .result(result), .status(status),
        .err(err), .alu_a(alu_a), .alu_b(alu_b), .gin(gin),
        .alu_sum(alu_sum), .alu_status(alu_status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational ALU the sequencer drives.
    always_comb begin
        logic [31:0] s;
        logic        v;
        s = 32'd0;
        v = 1'b0;
        case (gin)
            3'b010: begin s = alu_a + alu_b; v = (alu_a[31] == alu_b[31]) && (s[31] != alu_a[31]); end
            3'b110: begin s = alu_a - alu_b; v = (alu_a[31] != alu_b[31]) && (s[31] != alu_a[31]); end
            3'b000: s = alu_a & alu_b;
            3'b001: s = alu_a | alu_b;
            3'b111: s = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
            3'b101: s = alu_a << alu_b[4:0];
            default: s = 32'd0;
        endcase
        alu_sum    = s;
        alu_status = {s == 32'd0, s[31], v};
    end

    // Operation-level reference: result, status, err, latency and the EXEC control code.
    function automatic void model(input logic [1:0] op, input logic [5:0] fn,
                                  input logic [31:0] av, input logic [31:0] bv,
                                  output logic [31:0] er, output logic [2:0] es,
                                  output logic ee, output int el, output logic [2:0] eg);
        logic v;
        string kind;
        v = 1'b0;
        kind = "ill";
        if (op == 2'b00) kind = "add";
        else if (op == 2'b01) kind = "sub";
        else if (op == 2'b10) begin
            if (fn == 6'b100000) kind = "add";
            else if (fn == 6'b100010) kind = "sub";
            else if (fn == 6'b100100) kind = "and";
            else if (fn == 6'b100101) kind = "or";
            else if (fn == 6'b101010) kind = "slt";
            else if (fn == 6'b000000) kind = "sll";
            else if (fn == 6'b011000) kind = "mul";
        end
        er = 32'd0; es = 3'b000; ee = 1'b0; el = 2; eg = 3'b010;
        case (kind)
            "add": begin er = av + bv; v = (av[31] == bv[31]) && (er[31] != av[31]); eg = 3'b010; end
            "sub": begin er = av - bv; v = (av[31] != bv[31]) && (er[31] != av[31]); eg = 3'b110; end
            "and": begin er = av & bv; eg = 3'b000; end
            "or":  begin er = av | bv; eg = 3'b001; end
            "slt": begin er = ($signed(av) < $signed(bv)) ? 32'd1 : 32'd0; eg = 3'b111; end
            "sll": begin er = av << bv[4:0]; eg = 3'b101; end
            "mul": begin er = av * bv; el = 33; end
            default: begin er = 32'd0; ee = 1'b1; el = 1; end
        endcase
        if (kind != "ill") es = {er == 32'd0, er[31], v};
    endfunction

    task automatic run_op(input string nm, input logic [1:0] op, input logic [5:0] fn,
                          input logic [31:0] av, input logic [31:0] bv,
                          input int exp_wait, input bit poke, input bit hold_chk);
        logic [31:0] er;
        logic [2:0]  es;
        logic        ee;
        int          el;
        logic [2:0]  eg;
        int          w;
        int          cyc;
        bit          seen;
        model(op, fn, av, bv, er, es, ee, el, eg);
        @(negedge clk);
        start = 1'b1; aluop = op; funct = fn; a = av; b = bv;
        w = 0; seen = 1'b0;
        while (!seen && w < 5) begin
            @(posedge clk); #1;
            w++;
            if (busy) seen = 1'b1;
        end
        start = 1'b0; a = $urandom; b = $urandom; aluop = 2'($urandom); funct = 6'($urandom);
        checks++;
        if (!seen) begin errors++; $display("FAIL %s accept: busy never rose", nm); end
        if (exp_wait != 0) begin
            checks++;
            if (w != exp_wait) begin errors++; $display("FAIL %s accept_wait: got %0d want %0d", nm, w, exp_wait); end
        end
        if (el == 2) begin
            checks++;
            if ({alu_a, alu_b, gin} !== {av, bv, eg}) begin
                errors++;
                $display("FAIL %s exec_drive: got a=%h b=%h gin=%b want a=%h b=%h gin=%b", nm, alu_a, alu_b, gin, av, bv, eg);
            end
        end
        if (el == 33) begin
            checks++;
            if ({alu_a, gin} !== {32'd0, 3'b010}) begin
                errors++;
                $display("FAIL %s mult_first: got a=%h gin=%b want a=0 gin=010", nm, alu_a, gin);
            end
        end
        cyc = 1;
        while (!done && cyc < 40) begin
            start = (poke && cyc == 5) ? 1'b1 : 1'b0;
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        checks++;
        if (!done) begin errors++; $display("FAIL %s done_timeout: no done within 40 cycles", nm); end
        checks++;
        if (cyc != el) begin errors++; $display("FAIL %s latency: got %0d want %0d", nm, cyc, el); end
        checks++;
        if ({result, status, err, busy} !== {er, es, ee, 1'b1}) begin
            errors++;
            $display("FAIL %s result: got r=%h s=%b e=%b busy=%b want r=%h s=%b e=%b busy=1",
                     nm, result, status, err, busy, er, es, ee);
        end
        if (hold_chk) begin
            @(posedge clk); #1;
            checks++;
            if ({done, busy, result, status, err, gin} !== {1'b0, 1'b0, er, es, ee, 3'b010}) begin
                errors++;
                $display("FAIL %s hold: got done=%b busy=%b r=%h s=%b e=%b gin=%b want 0 0 r=%h s=%b e=%b gin=010",
                         nm, done, busy, result, status, err, gin, er, es, ee);
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; aluop = 2'b00; funct = 6'd0; a = 32'd0; b = 32'd0;
        #12;
        checks++;
        if ({busy, done, result, status, err, alu_a, alu_b, gin} !== {1'b0, 1'b0, 32'd0, 3'b000, 1'b0, 32'd0, 32'd0, 3'b010}) begin
            errors++;
            $display("FAIL reset_state: got busy=%b done=%b r=%h s=%b e=%b a=%h b=%h gin=%b want all zero gin=010",
                     busy, done, result, status, err, alu_a, alu_b, gin);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({busy, done} !== 2'b00) begin errors++; $display("FAIL reset_idle: got busy=%b done=%b want 0 0", busy, done); end
    endtask

    task automatic test_directed;
        run_op("add",   2'b00, 6'b000000, 32'd5, 32'd7, 1, 1'b0, 1'b1);
        run_op("subz",  2'b10, 6'b100010, 32'd3, 32'd3, 1, 1'b0, 1'b1);
        run_op("slt",   2'b10, 6'b101010, 32'hFFFF_FFFF, 32'd1, 1, 1'b0, 1'b1);
        run_op("mult",  2'b10, 6'b011000, 32'd7, 32'hFFFF_FFFD, 1, 1'b1, 1'b1);
        run_op("ill",   2'b10, 6'b111111, 32'd9, 32'd4, 1, 1'b0, 1'b1);
        run_op("ill11", 2'b11, 6'b100000, 32'd1, 32'd2, 1, 1'b0, 1'b1);
        run_op("sll",   2'b10, 6'b000000, 32'h0000_0003, 32'd4, 1, 1'b0, 1'b1);
        run_op("addov", 2'b00, 6'b000000, 32'h7FFF_FFFF, 32'd1, 1, 1'b0, 1'b1);
    endtask

    task automatic test_random;
        logic [5:0] legal [7];
        logic [5:0] fn;
        legal[0] = 6'b100000; legal[1] = 6'b100010; legal[2] = 6'b100100; legal[3] = 6'b100101;
        legal[4] = 6'b101010; legal[5] = 6'b000000; legal[6] = 6'b011000;
        for (int i = 0; i < 40; i++) begin
            int sel;
            sel = int'($urandom_range(0, 9));
            fn = (sel < 7) ? legal[sel] : 6'($urandom);
            run_op("rand", 2'($urandom), fn, $urandom, $urandom, 1, 1'b0, 1'b1);
        end
    endtask

    task automatic test_back_to_back;
        run_op("b2b_add", 2'b00, 6'b000000, 32'd100, 32'd23, 1, 1'b0, 1'b0);
        run_op("b2b_ill", 2'b10, 6'b000001, 32'd1, 32'd1, 2, 1'b0, 1'b0);
        run_op("b2b_mul", 2'b10, 6'b011000, 32'h0001_0003, 32'h0002_0005, 2, 1'b0, 1'b0);
        run_op("b2b_or",  2'b10, 6'b100101, 32'hF0F0_0000, 32'h0000_0F0F, 2, 1'b0, 1'b1);
    endtask

    task automatic test_reset_abort;
        bit saw_done;
        @(negedge clk);
        start = 1'b1; aluop = 2'b10; funct = 6'b011000; a = 32'd123; b = 32'd456;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, result, status, err, alu_a, alu_b, gin} !== {1'b0, 1'b0, 32'd0, 3'b000, 1'b0, 32'd0, 32'd0, 3'b010}) begin
            errors++;
            $display("FAIL abort_reset: got busy=%b done=%b r=%h s=%b e=%b a=%h b=%h gin=%b want all zero gin=010",
                     busy, done, result, status, err, alu_a, alu_b, gin);
        end
        @(negedge clk); rst_n = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done || busy) saw_done = 1'b1;
        end
        checks++;
        if (saw_done) begin errors++; $display("FAIL abort_no_done: got activity after reset want none"); end
        run_op("post_reset_add", 2'b00, 6'b000000, 32'd1, 32'd1, 1, 1'b0, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
